// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants, channel codes and FSM state type for the ADC SPI responder
package adc_pkg;

    localparam int FRAME_BITS = 16;
    localparam int SAMPLE_W   = 13;

    localparam logic [1:0] CHAN_V_I  = 2'b00;
    localparam logic [1:0] CHAN_V_O  = 2'b01;
    localparam logic [1:0] CHAN_TEMP = 2'b10;
    localparam logic [1:0] CHAN_I_IN = 2'b11;

    localparam int CMD_CHAN_HI = 13;
    localparam int CMD_CHAN_LO = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        HOLD  = 2'b11
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchroniser with rise/fall pulses on the synchronised value
// STAGES must be at least 2.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI mode-0 slave returning one ADC channel sample per frame
// The channel served in a frame is the one commanded by the previous complete frame.
module adc_spi_responder #(
    parameter int FRAME_BITS  = adc_pkg::FRAME_BITS,
    parameter int SAMPLE_W    = adc_pkg::SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SAMPLE_W-1:0]   v_i,
    input  logic [SAMPLE_W-1:0]   v_o,
    input  logic [SAMPLE_W-1:0]   temp,
    input  logic [SAMPLE_W-1:0]   i_in,
    output logic [FRAME_BITS-1:0] cmd,
    output logic                  frame_done,
    output logic                  frame_err
);

    import adc_pkg::*;

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    state_t r_state, w_next_state;

    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;
    logic [FRAME_BITS-1:0] r_cmd;
    logic [CNT_W-1:0]      r_count;
    logic [1:0]            r_chan_sel;
    logic                  r_miso;
    logic                  r_miso_oe;
    logic                  r_frame_done;
    logic                  r_frame_err;

    logic                  w_sclk_rise_q, w_sclk_fall_q;
    logic                  w_load, w_shift_in, w_shift_out, w_last;
    logic                  w_done, w_err;
    logic [SAMPLE_W-1:0]   w_sample;
    logic [FRAME_BITS-1:0] w_tx_word;
    logic [FRAME_BITS-1:0] w_rx_next;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .i_async(ss_n),
        .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_sync, w_mosi_rise, w_mosi_fall};

    // A deselected bus never clocks the shifters.
    assign w_sclk_rise_q = w_sclk_rise & ~w_ss_sync;
    assign w_sclk_fall_q = w_sclk_fall & ~w_ss_sync;

    always_comb begin
        w_sample = v_i;
        case (r_chan_sel)
            CHAN_V_I:  w_sample = v_i;
            CHAN_V_O:  w_sample = v_o;
            CHAN_TEMP: w_sample = temp;
            CHAN_I_IN: w_sample = i_in;
            default:   w_sample = v_i;
        endcase
    end

    assign w_tx_word = {{(FRAME_BITS-SAMPLE_W){1'b0}}, w_sample};
    assign w_rx_next = {r_rx[FRAME_BITS-2:0], w_mosi_sync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ss_n rise is tested before any sclk edge so a coincident edge is dropped.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift_in   = 1'b0;
        w_shift_out  = 1'b0;
        w_last       = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                if (w_ss_rise) begin
                    w_err        = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_ss_rise) begin
                    w_err        = 1'b1;
                    w_next_state = IDLE;
                end else if (w_sclk_rise_q) begin
                    w_shift_in = 1'b1;
                    if (r_count == CNT_W'(FRAME_BITS - 1)) begin
                        w_last       = 1'b1;
                        w_next_state = HOLD;
                    end
                end else if (w_sclk_fall_q) begin
                    w_shift_out = 1'b1;
                end
            end
            HOLD: begin
                if (w_ss_rise) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx         <= '0;
            r_rx         <= '0;
            r_cmd        <= '0;
            r_count      <= '0;
            r_chan_sel   <= CHAN_V_I;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
            if (w_load) begin
                r_tx      <= w_tx_word;
                r_rx      <= '0;
                r_count   <= '0;
                r_miso    <= w_tx_word[FRAME_BITS-1];
                r_miso_oe <= 1'b1;
            end
            if (w_shift_in) begin
                r_rx    <= w_rx_next;
                r_count <= r_count + CNT_W'(1);
            end
            if (w_last) begin
                r_cmd      <= w_rx_next;
                r_chan_sel <= w_rx_next[CMD_CHAN_HI:CMD_CHAN_LO];
                r_miso     <= 1'b0;
            end
            if (w_shift_out) begin
                r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                r_miso <= r_tx[FRAME_BITS-2];
            end
            if (w_next_state == IDLE) begin
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end
        end
    end

    assign miso       = r_miso;
    assign miso_oe    = r_miso_oe;
    assign cmd        = r_cmd;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed SPI master bench for adc_spi_responder
module tb_adc_spi_responder;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [12:0] v_i, v_o, temp, i_in;
    logic [15:0] cmd;
    logic        frame_done;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;

    adc_spi_responder #(.FRAME_BITS(16), .SAMPLE_W(13), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .v_i(v_i), .v_o(v_o), .temp(temp), .i_in(i_in),
        .cmd(cmd), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) n_done <= n_done + 1;
        if (frame_err)  n_err  <= n_err + 1;
        if (frame_done && frame_err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, input bit raise_ss,
                             input int vo_at, input logic [12:0] vo_val,
                             output logic [15:0] rx, output logic hold_miso, output logic hold_oe);
        rx        = '0;
        hold_miso = 1'b0;
        hold_oe   = 1'b1;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b0;
            if (i == vo_at) v_o = vo_val;
            repeat (HALF) @(negedge clk);
            if (i < 16) begin
                rx[15-i] = miso;
            end else begin
                hold_miso = hold_miso | miso;
                hold_oe   = hold_oe & miso_oe;
            end
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        if (raise_ss) begin
            repeat (HALF) @(negedge clk);
            ss_n = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    logic [15:0] rx;
    logic        hm, ho;
    int          d0, e0;

    initial begin
        rst_n = 1'b0;
        ss_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        v_i   = 13'h0ABC;
        v_o   = 13'h1234;
        temp  = 13'h1FFF;
        i_in  = 13'h0F0F;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_cmd", cmd, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        d0 = n_done; e0 = n_err;
        spi_frame(16'h2000, 16, 1'b1, -1, 13'h0, rx, hm, ho);
        check("f1_miso", rx, 16'h0ABC);
        check("f1_cmd", cmd, 16'h2000);
        check("f1_done", n_done - d0, 1);
        check("f1_err", n_err - e0, 0);
        check("f1_oe_idle", miso_oe, 0);

        d0 = n_done; e0 = n_err;
        spi_frame(16'h0000, 16, 1'b1, -1, 13'h0, rx, hm, ho);
        check("f2_miso_temp", rx, 16'h1FFF);
        check("f2_cmd", cmd, 16'h0000);
        check("f2_done", n_done - d0, 1);

        d0 = n_done; e0 = n_err;
        spi_frame(16'h3000, 9, 1'b1, -1, 13'h0, rx, hm, ho);
        check("f3_err", n_err - e0, 1);
        check("f3_done", n_done - d0, 0);
        check("f3_cmd_kept", cmd, 16'h0000);

        d0 = n_done; e0 = n_err;
        spi_frame(16'h1000, 20, 1'b1, -1, 13'h0, rx, hm, ho);
        check("f4_miso_prev_chan", rx, 16'h0ABC);
        check("f4_cmd", cmd, 16'h1000);
        check("f4_hold_miso", hm, 0);
        check("f4_hold_oe", ho, 1);
        check("f4_done", n_done - d0, 1);
        check("f4_err", n_err - e0, 0);

        spi_frame(16'h3000, 16, 1'b1, 8, 13'h0555, rx, hm, ho);
        check("f5_miso_vo_captured", rx, 16'h1234);
        check("f5_cmd", cmd, 16'h3000);

        d0 = n_done; e0 = n_err;
        spi_frame(16'h2000, 8, 1'b0, -1, 13'h0, rx, hm, ho);
        check("f6_oe_before_rst", miso_oe, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("f6_oe_async", miso_oe, 0);
        check("f6_miso_async", miso, 0);
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("f6_no_done", n_done - d0, 0);
        check("f6_no_err", n_err - e0, 0);
        check("f6_cmd_rst", cmd, 0);

        d0 = n_done;
        spi_frame(16'h0000, 16, 1'b1, -1, 13'h0, rx, hm, ho);
        check("f7_miso_vi", rx, 16'h0ABC);
        check("f7_done", n_done - d0, 1);
        check("never_both", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL take parameter FRAME_BITS, 16, SPI frame length in sclk cycles.
REQ-002 SHALL take parameter SAMPLE_W, 13, width of each channel sample.
REQ-003 SHALL take parameter SYNC_STAGES, 2, flip-flop stages on each SPI input.
REQ-004 SHALL have port clk  input  1  system clock; one clock only.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports sclk, ss_n, mosi  input  1 each  SPI bus from the master; asynchronous to clk.
REQ-007 SHALL have port miso  output  1  SPI serial data to the master.
REQ-008 SHALL have port miso_oe  output  1  miso tristate enable, high only while selected.
REQ-009 SHALL have ports v_i, v_o, temp, i_in  input  SAMPLE_W each  parallel channel samples.
REQ-010 SHALL have port cmd  output  FRAME_BITS  last complete word received on mosi.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse per complete frame.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse per truncated frame.

Function
REQ-013 SHALL implement SPI mode 0 (cpol=0, cpha=0), MSB first: mosi sampled on sclk rise, miso changed on sclk fall.
REQ-014 SHALL pass sclk, ss_n, mosi through SYNC_STAGES flops (ss_n resets to 1, others to 0), edge-detecting on the synchronised values.
REQ-015 SHALL meet timing only for sclk half-period >= 3 clk and ss_n fall to first sclk rise >= 4 clk.
REQ-016 SHALL use states IDLE, LOAD, SHIFT, HOLD.
REQ-017 IDLE: miso=0, miso_oe=0; synchronised ss_n fall -> LOAD.
REQ-018 LOAD (exactly 1 cycle): tx shift <= {3'b000, sample of chan_sel}, bit count <= 0, miso_oe <= 1, miso <= tx MSB; -> SHIFT.
REQ-019 Channel map SHALL be 00 v_i, 01 v_o, 10 temp, 11 i_in; sample captured only in LOAD, stable for the whole frame.
REQ-020 SHIFT: each sclk rise shifts mosi into rx shift register and increments count; each sclk fall shifts tx left and drives the next bit on miso.
REQ-021 On the FRAME_BITS-th sclk rise: cmd <= full rx word (including that bit), chan_sel <= rx word bits [13:12]; -> HOLD.
REQ-022 Response SHALL be pipelined: data in frame N is from the channel commanded in frame N-1; first frame after reset returns v_i.
REQ-023 HOLD: miso=0, miso_oe=1; further sclk edges ignored; ss_n rise -> frame_done=1 for one cycle, miso_oe=0, -> IDLE.
REQ-024 ss_n rise in LOAD or SHIFT (count < FRAME_BITS): frame_err=1 for one cycle, cmd and chan_sel unchanged, -> IDLE.
REQ-025 sclk edges while ss_n synchronised high SHALL be ignored.
REQ-026 ss_n rise and sclk edge in the same cycle: the ss_n rise takes priority; the sclk edge is discarded.
REQ-027 frame_done and frame_err SHALL never assert in the same cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, miso=0, miso_oe=0, cmd=0, chan_sel=00, count=0, frame_done=0, frame_err=0, synchronisers to idle bus values.
REQ-029 Reset mid-frame SHALL abandon the frame without a frame_done/frame_err pulse; the next ss_n fall after reset release starts a new frame.

Structure
REQ-030 Package adc_pkg SHALL hold FRAME_BITS, SAMPLE_W, channel code constants, command channel-field position [13:12], and the state enum.
REQ-031 Sub-module sync_edge (SYNC_STAGES synchroniser with rise/fall pulses) SHALL be instantiated once per SPI input.

Verification
REQ-032 Reset, v_i=0x0ABC, 16-clk sclk, mosi=0x2000 -> miso returns 0x0ABC, cmd=0x2000, frame_done once.
REQ-033 Next frame, temp=0x1FFF, mosi=0x0000 -> miso returns 0x1FFF (pipelined), chan_sel -> 00.
REQ-034 ss_n raised after 9 sclk cycles with mosi=0x3000 -> frame_err once, no frame_done, cmd unchanged, next frame still uses previous channel.
REQ-035 20 sclk cycles in one frame, mosi=0x1000 -> cmd=0x1000 after 16, bits 17-20 ignored, miso=0 in HOLD.
REQ-036 rst_n low at bit 8 -> miso_oe=0 immediately, no pulses; following frame returns v_i.
REQ-037 v_o changed mid-frame with channel 01 selected -> miso carries the value captured at LOAD.
